// File: rtl/sap1_pkg.sv
// Shared SAP-1 controller definitions: opcodes, T-state indices and control-word layout.
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int unsigned T1 = 0;
    localparam int unsigned T2 = 1;
    localparam int unsigned T3 = 2;
    localparam int unsigned T4 = 3;
    localparam int unsigned T5 = 4;
    localparam int unsigned T6 = 5;

    localparam int unsigned CON_W  = 12;
    localparam int unsigned CON_CP = 11;
    localparam int unsigned CON_EP = 10;
    localparam int unsigned CON_LM = 9;
    localparam int unsigned CON_CE = 8;
    localparam int unsigned CON_LI = 7;
    localparam int unsigned CON_EI = 6;
    localparam int unsigned CON_LA = 5;
    localparam int unsigned CON_EA = 4;
    localparam int unsigned CON_SU = 3;
    localparam int unsigned CON_EU = 2;
    localparam int unsigned CON_LB = 1;
    localparam int unsigned CON_LO = 0;

    typedef logic [CON_W-1:0] con_word_t;

    // Active-low strobes sit at 1 when idle.
    localparam con_word_t CON_IDLE = 12'b0011_1110_0011;

    localparam logic [5:0] RING_T1 = 6'b000001;

    function automatic logic is_onehot6(input logic [5:0] s);
        return (s != 6'd0) && ((s & (s - 6'd1)) == 6'd0);
    endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// Six-bit one-hot T-state ring; steps on the falling clock edge, async clear to T1.
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_adv,
    input  logic       i_load_t1,
    output logic [5:0] o_state
);

    logic [5:0] r_state;
    logic [5:0] w_next;

    always_comb begin
        w_next = r_state;
        if (i_adv) begin
            // A corrupted (non one-hot) ring recovers to T1 on its next step.
            if (i_load_t1 || !is_onehot6(r_state)) begin
                w_next = RING_T1;
            end else begin
                w_next = {r_state[4:0], r_state[5]};
            end
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RING_T1;
        end else begin
            r_state <= w_next;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/sap1_ctrl_seq.sv
// SAP-1 controller-sequencer: ring counter plus Moore decode of {T-state, opcode}.
module sap1_ctrl_seq
    import sap1_pkg::*;
#(
    parameter int unsigned EARLY_END = 0,
    parameter int unsigned OPW       = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run,
    input  logic [OPW-1:0] opcode,
    output logic [5:0]     t_state,
    output logic           Cp,
    output logic           Ep,
    output logic           Lm_n,
    output logic           Ce_n,
    output logic           Li_n,
    output logic           Ei_n,
    output logic           La_n,
    output logic           Ea,
    output logic           Su,
    output logic           Eu,
    output logic           Lb_n,
    output logic           Lo_n,
    output logic           hlt
);

    logic      r_hlt;
    logic      w_hlt_d;
    logic      w_adv;
    logic      w_load_t1;
    logic      w_legal;
    logic      w_mem_op;
    logic      w_known_op;
    logic [5:0] w_t;
    con_word_t w_con;

    assign w_legal    = is_onehot6(w_t);
    assign w_mem_op   = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB);
    assign w_known_op = w_mem_op || (opcode == OP_OUT) || (opcode == OP_HLT);
    assign w_adv      = run && !r_hlt;

    assign w_hlt_d = r_hlt || (w_adv && w_legal && w_t[T3] && (opcode == OP_HLT));

    // Short instructions return to fetch right after their last active T-state.
    assign w_load_t1 = (EARLY_END != 0) &&
                       ((w_t[T5] && (opcode == OP_LDA)) ||
                        (w_t[T4] && ((opcode == OP_OUT) || !w_known_op)));

    sap1_ring_counter u_ring (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_adv     (w_adv),
        .i_load_t1 (w_load_t1),
        .o_state   (w_t)
    );

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hlt <= 1'b0;
        end else begin
            r_hlt <= w_hlt_d;
        end
    end

    always_comb begin
        w_con = CON_IDLE;
        // Reset gates the decode combinationally so no strobe survives rst_n falling.
        if (rst_n && !r_hlt && w_legal) begin
            unique case (1'b1)
                w_t[T1]: begin
                    w_con[CON_EP] = 1'b1;
                    w_con[CON_LM] = 1'b0;
                end
                w_t[T2]: w_con[CON_CP] = 1'b1;
                w_t[T3]: begin
                    w_con[CON_CE] = 1'b0;
                    w_con[CON_LI] = 1'b0;
                end
                w_t[T4]: begin
                    if (w_mem_op) begin
                        w_con[CON_EI] = 1'b0;
                        w_con[CON_LM] = 1'b0;
                    end else if (opcode == OP_OUT) begin
                        w_con[CON_EA] = 1'b1;
                        w_con[CON_LO] = 1'b0;
                    end
                end
                w_t[T5]: begin
                    if (opcode == OP_LDA) begin
                        w_con[CON_CE] = 1'b0;
                        w_con[CON_LA] = 1'b0;
                    end else if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        w_con[CON_CE] = 1'b0;
                        w_con[CON_LB] = 1'b0;
                    end
                end
                w_t[T6]: begin
                    if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        w_con[CON_EU] = 1'b1;
                        w_con[CON_LA] = 1'b0;
                        w_con[CON_SU] = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign t_state = w_t;
    assign hlt     = r_hlt;
    assign Cp      = w_con[CON_CP];
    assign Ep      = w_con[CON_EP];
    assign Lm_n    = w_con[CON_LM];
    assign Ce_n    = w_con[CON_CE];
    assign Li_n    = w_con[CON_LI];
    assign Ei_n    = w_con[CON_EI];
    assign La_n    = w_con[CON_LA];
    assign Ea      = w_con[CON_EA];
    assign Su      = w_con[CON_SU];
    assign Eu      = w_con[CON_EU];
    assign Lb_n    = w_con[CON_LB];
    assign Lo_n    = w_con[CON_LO];

endmodule

// File: tb/tb_sap1_ctrl_seq.sv
// Directed bench for sap1_ctrl_seq: per-T-state control table plus halt/run/reset/early-end cases.
module tb_sap1_ctrl_seq;

    // Control word order: Cp Ep Lm_n Ce_n Li_n Ei_n La_n Ea Su Eu Lb_n Lo_n
    localparam logic [11:0] W_IDLE  = 12'b001111100011;
    localparam logic [11:0] W_T1    = 12'b010111100011;
    localparam logic [11:0] W_T2    = 12'b101111100011;
    localparam logic [11:0] W_T3    = 12'b001001100011;
    localparam logic [11:0] W_T4M   = 12'b000110100011;
    localparam logic [11:0] W_T4OUT = 12'b001111110010;
    localparam logic [11:0] W_T5LDA = 12'b001011000011;
    localparam logic [11:0] W_T5AS  = 12'b001011100001;
    localparam logic [11:0] W_T6ADD = 12'b001111000111;
    localparam logic [11:0] W_T6SUB = 12'b001111001111;

    localparam logic [5:0] S1 = 6'b000001;
    localparam logic [5:0] S2 = 6'b000010;
    localparam logic [5:0] S3 = 6'b000100;
    localparam logic [5:0] S4 = 6'b001000;
    localparam logic [5:0] S5 = 6'b010000;
    localparam logic [5:0] S6 = 6'b100000;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [3:0] opcode;

    logic [5:0] ts0, ts1;
    logic Cp0, Ep0, Lm0, Ce0, Li0, Ei0, La0, Ea0, Su0, Eu0, Lb0, Lo0, hlt0;
    logic Cp1, Ep1, Lm1, Ce1, Li1, Ei1, La1, Ea1, Su1, Eu1, Lb1, Lo1, hlt1;
    logic [11:0] cw0;

    assign cw0 = {Cp0, Ep0, Lm0, Ce0, Li0, Ei0, La0, Ea0, Su0, Eu0, Lb0, Lo0};

    sap1_ctrl_seq #(.EARLY_END(0), .OPW(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .t_state(ts0),
        .Cp(Cp0), .Ep(Ep0), .Lm_n(Lm0), .Ce_n(Ce0), .Li_n(Li0), .Ei_n(Ei0),
        .La_n(La0), .Ea(Ea0), .Su(Su0), .Eu(Eu0), .Lb_n(Lb0), .Lo_n(Lo0), .hlt(hlt0)
    );

    sap1_ctrl_seq #(.EARLY_END(1), .OPW(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .t_state(ts1),
        .Cp(Cp1), .Ep(Ep1), .Lm_n(Lm1), .Ce_n(Ce1), .Li_n(Li1), .Ei_n(Ei1),
        .La_n(La1), .Ea(Ea1), .Su(Su1), .Eu(Eu1), .Lb_n(Lb1), .Lo_n(Lo1), .hlt(hlt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic [3:0]  op;
        logic [5:0]  ts;
        logic [11:0] cw;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] op, input logic [5:0] ts,
                       input logic [11:0] cw);
        vec_t v;
        v.rst = r;
        v.op  = op;
        v.ts  = ts;
        v.cw  = cw;
        tbl.push_back(v);
    endtask

    // Leaves the ring at T1 just after a falling edge; first sample shows T1.
    task automatic do_reset(input logic [3:0] op);
        @(negedge clk);
        #1;
        rst_n  = 1'b0;
        opcode = op;
        run    = 1'b1;
        #1;
        check("reset_state", {13'd0, hlt0, ts0, cw0}, {13'd0, 1'b0, S1, W_IDLE});
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic measure(input logic [3:0] op, input bit sel, output int n);
        logic [5:0] t;
        do_reset(op);
        @(posedge clk);
        #1;
        n = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            t = sel ? ts1 : ts0;
            if (n == 99 && t == S1) n = i;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        run    = 1'b1;
        opcode = 4'h0;

        add(1, 4'h0, S1, W_T1);  add(0, 4'h0, S2, W_T2);    add(0, 4'h0, S3, W_T3);
        add(0, 4'h0, S4, W_T4M); add(0, 4'h0, S5, W_T5LDA); add(0, 4'h0, S6, W_IDLE);
        add(0, 4'h0, S1, W_T1);
        add(1, 4'h1, S1, W_T1);  add(0, 4'h1, S2, W_T2);    add(0, 4'h1, S3, W_T3);
        add(0, 4'h1, S4, W_T4M); add(0, 4'h1, S5, W_T5AS);  add(0, 4'h1, S6, W_T6ADD);
        add(1, 4'h2, S1, W_T1);  add(0, 4'h2, S2, W_T2);    add(0, 4'h2, S3, W_T3);
        add(0, 4'h2, S4, W_T4M); add(0, 4'h2, S5, W_T5AS);  add(0, 4'h2, S6, W_T6SUB);
        add(1, 4'hE, S1, W_T1);  add(0, 4'hE, S2, W_T2);    add(0, 4'hE, S3, W_T3);
        add(0, 4'hE, S4, W_T4OUT); add(0, 4'hE, S5, W_IDLE); add(0, 4'hE, S6, W_IDLE);
        add(0, 4'hE, S1, W_T1);
        add(1, 4'h5, S1, W_T1);  add(0, 4'h5, S2, W_T2);    add(0, 4'h5, S3, W_T3);
        add(0, 4'h5, S4, W_IDLE); add(0, 4'h5, S5, W_IDLE); add(0, 4'h5, S6, W_IDLE);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset(tbl[i].op);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_op%h", i, tbl[i].op), {13'd0, hlt0, ts0, cw0},
                  {13'd0, 1'b0, tbl[i].ts, tbl[i].cw});
        end

        // HLT freezes at T4 and only reset clears it.
        do_reset(4'hF);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        check("hlt_enter_t4", {13'd0, hlt0, ts0, cw0}, {13'd0, 1'b1, S4, W_IDLE});
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hlt_hold%0d", i), {13'd0, hlt0, ts0, cw0},
                  {13'd0, 1'b1, S4, W_IDLE});
        end
        rst_n = 1'b0;
        #1;
        check("hlt_async_rst", {13'd0, hlt0, ts0, cw0}, {13'd0, 1'b0, S1, W_IDLE});
        rst_n = 1'b1;
        #1;
        check("post_rst_t1", {13'd0, hlt0, ts0, cw0}, {13'd0, 1'b0, S1, W_T1});

        // Early-end instruction lengths.
        measure(4'h0, 1'b1, cyc); check("ee_lda_len", cyc, 5);
        measure(4'hE, 1'b1, cyc); check("ee_out_len", cyc, 4);
        measure(4'h5, 1'b1, cyc); check("ee_nop_len", cyc, 4);
        measure(4'h2, 1'b1, cyc); check("ee_sub_len", cyc, 6);
        measure(4'h0, 1'b0, cyc); check("full_lda_len", cyc, 6);

        // run=0 in T3 holds the state and its controls.
        do_reset(4'h0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("run_t3", {13'd0, hlt0, ts0, cw0}, {13'd0, 1'b0, S3, W_T3});
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("run_hold%0d", i), {13'd0, hlt0, ts0, cw0},
                  {13'd0, 1'b0, S3, W_T3});
        end
        run = 1'b1;
        @(posedge clk);
        #1;
        check("run_resume_t4", {13'd0, hlt0, ts0, cw0}, {13'd0, 1'b0, S4, W_T4M});
        @(posedge clk);
        #1;
        check("lda_t5", {13'd0, hlt0, ts0, cw0}, {13'd0, 1'b0, S5, W_T5LDA});
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_t5_rst_la", {31'd0, La0}, {31'd0, 1'b1});
        check("mid_t5_rst_state", {13'd0, hlt0, ts0, cw0}, {13'd0, 1'b0, S1, W_IDLE});
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
